// File: rtl/bcd_scan_counter.sv
// Cascaded BCD up/down counter with multiplexed 7-segment scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_scan_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 5000000,
  parameter int SCAN_DIV   = 5000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    wrap,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  logic [TW-1:0]           tick_cnt;
  logic                    step;
  logic [4*NUM_DIGITS-1:0] count_nxt;
  logic                    carry;
  logic [SW-1:0]           scan_cnt;
  logic                    scan_tc;
  logic [NUM_DIGITS-1:0]   sel_nxt;
  logic [3:0]              cur_digit;
  logic                    cur_blank;
  logic [7:0]              seg_nxt;

  assign step = en && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (clr) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= step ? '0 : tick_cnt + TW'(1);
    end
  end

  // Ripple carry/borrow through the digits; carry out of the top is the wrap.
  always_comb begin
    count_nxt = count_bcd;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (up_dn) begin
          if (count_bcd[4*i +: 4] == 4'd9) begin
            count_nxt[4*i +: 4] = 4'd0;
          end else begin
            count_nxt[4*i +: 4] = count_bcd[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (count_bcd[4*i +: 4] == 4'd0) begin
            count_nxt[4*i +: 4] = 4'd9;
          end else begin
            count_nxt[4*i +: 4] = count_bcd[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_bcd <= '0;
      wrap      <= 1'b0;
    end else if (clr) begin
      count_bcd <= '0;
      wrap      <= 1'b0;
    end else if (step) begin
      count_bcd <= count_nxt;
      wrap      <= carry;
    end else begin
      wrap      <= 1'b0;
    end
  end

  assign scan_tc = (scan_cnt == SCAN_LAST);

  always_comb begin
    sel_nxt = digit_sel;
    if (scan_tc) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        sel_nxt[i] = digit_sel[(i + NUM_DIGITS - 1) % NUM_DIGITS];
      end
    end
  end

  // Segments are encoded from the next selection so both update together.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_nxt[i]) cur_digit = count_bcd[4*i +: 4];
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    cur_blank  = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above && (count_bcd[4*i +: 4] == 4'd0);
      if (sel_nxt[i] && zero_above) cur_blank = 1'b1;
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  always_comb begin
    seg_nxt = 8'hFF;
    if (!cur_blank) begin
      case (cur_digit)
        4'd0: seg_nxt = 8'hC0;
        4'd1: seg_nxt = 8'hF9;
        4'd2: seg_nxt = 8'hA4;
        4'd3: seg_nxt = 8'hB0;
        4'd4: seg_nxt = 8'h99;
        4'd5: seg_nxt = 8'h92;
        4'd6: seg_nxt = 8'h82;
        4'd7: seg_nxt = 8'hF8;
        4'd8: seg_nxt = 8'h80;
        4'd9: seg_nxt = 8'h90;
        default: seg_nxt = 8'hFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt  <= '0;
      digit_sel <= NUM_DIGITS'(1);
      seg_out   <= 8'hC0;
    end else begin
      scan_cnt  <= scan_tc ? '0 : scan_cnt + SW'(1);
      digit_sel <= sel_nxt;
      seg_out   <= seg_nxt;
    end
  end

endmodule
